// File: rtl/lag_link_pkg.sv
// lag_link_pkg: flit/tag types and default sizing shared by the credit transmitter and the receiving FIFO bank
package lag_link_pkg;
  localparam int LINK_NUM_VC = 2;
  localparam int LINK_BUF_DEPTH = 8;
  localparam int LINK_FLIT_W = 32;
  localparam int LINK_VC_W = $clog2(LINK_NUM_VC);
  typedef logic [LINK_FLIT_W-1:0] flit_t;
  typedef struct packed {
    logic valid;
    logic [LINK_VC_W-1:0] vc;
  } link_tag_t;
endpackage

// File: rtl/lag_rr_arbiter.sv
// lag_rr_arbiter: round-robin arbiter; clk/rst, req[N] in, one-hot combinational grant[N] out, pointer moves past each winner
module lag_rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);
  localparam int PW = $clog2(N);
  logic [PW-1:0] ptr, win;
  always_comb begin
    int j;
    j = 0;
    grant = '0;
    win = ptr;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        win = PW'(j);
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) ptr <= '0;
    else if (|req) ptr <= (int'(win) == N - 1) ? '0 : win + 1'b1;
endmodule

// File: rtl/lag_credit_tx.sv
// lag_credit_tx: credit-flow-controlled link transmitter; per-VC in_valid/in_data/in_ready, registered out_valid/out_vc/out_data, cred_valid/cred_vc returns, credits and idle status
module lag_credit_tx import lag_link_pkg::*; #(
  parameter int NUM_VC = LINK_NUM_VC,
  parameter int BUF_DEPTH = LINK_BUF_DEPTH,
  parameter int FLIT_W = LINK_FLIT_W,
  localparam int CNT_W = $clog2(BUF_DEPTH + 1),
  localparam int VC_W = $clog2(NUM_VC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_VC-1:0]        in_valid,
  input  logic [NUM_VC*FLIT_W-1:0] in_data,
  output logic [NUM_VC-1:0]        in_ready,
  output logic                     out_valid,
  output logic [VC_W-1:0]          out_vc,
  output logic [FLIT_W-1:0]        out_data,
  input  logic                     cred_valid,
  input  logic [VC_W-1:0]          cred_vc,
  output logic [NUM_VC*CNT_W-1:0]  credits,
  output logic                     idle
);
  logic [NUM_VC-1:0] held, elig, grant, ret, at_full;
  logic [FLIT_W-1:0] hold_data [NUM_VC];
  logic [CNT_W-1:0] cred [NUM_VC];
  logic [VC_W-1:0] gvc;
  lag_rr_arbiter #(.N(NUM_VC)) u_arb (
    .clk(clk),
    .rst(rst),
    .req(elig),
    .grant(grant)
  );
  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign elig[v] = held[v] && cred[v] != '0;
    assign ret[v] = cred_valid && cred_vc == VC_W'(v);
    assign at_full[v] = cred[v] == CNT_W'(BUF_DEPTH);
    assign credits[v*CNT_W +: CNT_W] = cred[v];
  end
  assign in_ready = ~held | grant;
  assign idle = ~|held && &at_full && !out_valid;
  always_comb begin
    gvc = '0;
    for (int i = 0; i < NUM_VC; i++) gvc = grant[i] ? VC_W'(i) : gvc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      held <= '0;
      out_valid <= 1'b0;
      out_vc <= '0;
      out_data <= '0;
      for (int i = 0; i < NUM_VC; i++) cred[i] <= CNT_W'(BUF_DEPTH);
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          held[i] <= 1'b1;
          hold_data[i] <= in_data[i*FLIT_W +: FLIT_W];
        end else if (grant[i]) held[i] <= 1'b0;
        if (grant[i] && !ret[i]) cred[i] <= cred[i] - 1'b1;
        else if (ret[i] && !grant[i]) cred[i] <= cred[i] + 1'b1;
      end
      out_valid <= |grant;
      if (|grant) begin
        out_vc <= gvc;
        out_data <= hold_data[gvc];
      end
    end
  end
  // A return is legal at full credit only when the same VC spends one that cycle.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!$isunknown({in_valid, cred_valid})) else $fatal(1, "unknown value on in_valid/cred_valid");
      assert (!(cred_valid && int'(cred_vc) >= NUM_VC)) else $fatal(1, "credit return to nonexistent VC %0d", cred_vc);
      assert (!(cred_valid && int'(cred_vc) < NUM_VC && at_full[cred_vc] && !grant[cred_vc]))
        else $fatal(1, "credit overflow on VC %0d", cred_vc);
    end
  end
endmodule
